// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared definitions for the processor control unit.
//  - T0..T3 step encodings
//  - opcode values
//  - IR layout: {op[2:0], X[2:0], Y[2:0]}
//  - a helper that identifies the two-operand ALU opcodes
package proc_ctrl_pkg;

  localparam int IR_W = 9;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstate_e;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MVNZ = 3'b100
  } opcode_e;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
  } ir_t;

  // add and sub share the three-step A / G sequence.
  function automatic logic is_alu_op(logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/proc_ctrl_if.sv
// proc_ctrl_if: connects the control unit to the datapath and instruction source.
//  master (control unit):
//    in  Run, DIN, Gnz
//    out IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done, Busy, Illegal
//  slave (datapath / stimulus side): the same signals with opposite directions.
interface proc_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
);
  logic              Run;
  logic [DATA_W-1:0] DIN;
  logic              Gnz;
  logic              IRin;
  logic [NREG-1:0]   Rin;
  logic [NREG-1:0]   Rout;
  logic              Gout;
  logic              DINout;
  logic              Ain;
  logic              Gin;
  logic              AddSub;
  logic              Done;
  logic              Busy;
  logic              Illegal;

  modport master (
    input  Run, DIN, Gnz,
    output IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done, Busy, Illegal
  );

  modport slave (
    output Run, DIN, Gnz,
    input  IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done, Busy, Illegal
  );
endinterface

// File: rtl/proc_ctrl_dec3to8.sv
// dec3to8: 3-bit to 8-bit one-hot decoder with enable.
//  en_i   in  1  when 0, y_o is all zero
//  sel_i  in  3  index of the bit to set
//  y_o    out 8  one-hot (or zero) result
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] y_o
);
  always_comb begin
    y_o = '0;
    if (en_i) y_o[sel_i] = 1'b1;
  end
endmodule

// File: rtl/proc_ctrl.sv
// proc_ctrl: control-unit FSM for the 16-bit processor datapath.
//  Pclk    in  processor clock, rising edge
//  Resetn  in  asynchronous active-low reset (state -> T0, IR -> 0)
//  bus     proc_ctrl_if.master
//    Run/DIN/Gnz in
//    register-file, A/G and bus-mux enables out
//    Done/Busy/Illegal status out
//  The instruction is fetched from DIN in T0 when Run is high.
//  Each instruction then executes over one to three steps (T1..T3).
//  Every output is combinational from the step, IR, Run and Gnz.
module proc_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8   // fixed by the 3-bit X/Y fields
) (
  input  logic        Pclk,
  input  logic        Resetn,
  proc_ctrl_if.master bus
);

  tstate_e state_q, state_d;
  ir_t     ir_q, ir_d;
  ir_t     fetch_ir;

  logic       rin_en, rout_en;
  logic [2:0] rin_sel, rout_sel;
  logic       irin, gout, dinout, ain, gin, addsub, done, illegal;

  assign fetch_ir = ir_t'(bus.DIN[DATA_W-1 -: IR_W]);

  // Operand bits below the instruction field reach the datapath only through
  // DINout, so the controller never looks at them.
  logic unused_din_lo;
  assign unused_din_lo = ^bus.DIN[DATA_W-IR_W-1:0];

  always_ff @(posedge Pclk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    irin     = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rin_sel  = ir_q.x;
    rout_sel = ir_q.y;
    gout     = 1'b0;
    dinout   = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    addsub   = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;

    unique case (state_q)
      T0: begin
        // Reset holds the FSM in T0, so IRin follows Run during reset too.
        irin = bus.Run;
        if (bus.Run) begin
          ir_d    = fetch_ir;
          state_d = T1;
        end
      end

      T1: begin
        if (is_alu_op(ir_q.op)) begin
          // A <- Rx first; Ry is applied to the adder in T2.
          rout_en  = 1'b1;
          rout_sel = ir_q.x;
          ain      = 1'b1;
          state_d  = T2;
        end else begin
          done    = 1'b1;
          state_d = T0;
          case (ir_q.op)
            OP_MV: begin
              rout_en = 1'b1;
              rin_en  = 1'b1;
            end
            OP_MVI: begin
              dinout = 1'b1;
              rin_en = 1'b1;
            end
            OP_MVNZ: begin
              rout_en = bus.Gnz;
              rin_en  = bus.Gnz;
            end
            default: illegal = 1'b1;
          endcase
        end
      end

      // T2/T3 are reached only by add/sub.
      T2: begin
        rout_en = 1'b1;
        gin     = 1'b1;
        addsub  = (ir_q.op == OP_SUB);
        state_d = T3;
      end

      T3: begin
        gout    = 1'b1;
        rin_en  = 1'b1;
        done    = 1'b1;
        state_d = T0;
      end

      default: state_d = T0;
    endcase
  end

  dec3to8 u_rin_dec (
    .en_i  (rin_en),
    .sel_i (rin_sel),
    .y_o   (bus.Rin)
  );

  dec3to8 u_rout_dec (
    .en_i  (rout_en),
    .sel_i (rout_sel),
    .y_o   (bus.Rout)
  );

  assign bus.IRin    = irin;
  assign bus.Gout    = gout;
  assign bus.DINout  = dinout;
  assign bus.Ain     = ain;
  assign bus.Gin     = gin;
  assign bus.AddSub  = addsub;
  assign bus.Done    = done;
  assign bus.Illegal = illegal;
  assign bus.Busy    = (state_q != T0);

endmodule

// File: tb/tb_proc_ctrl.sv
module tb_proc_ctrl;

  logic Pclk;
  logic Resetn;

  proc_ctrl_if #(.DATA_W(16), .NREG(8)) pif ();

  proc_ctrl #(.DATA_W(16), .NREG(8)) dut (
    .Pclk   (Pclk),
    .Resetn (Resetn),
    .bus    (pif.master)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  typedef struct {
    logic        rstn;
    logic        run;
    logic [15:0] din;
    logic        gnz;
  } stim_t;

  typedef struct {
    string       tag;
    logic [24:0] v;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;
  logic  done_prev = 1'b0;

  // Output word: {IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done, Busy, Illegal}
  function automatic logic [24:0] mk(logic irin, logic [7:0] rin, logic [7:0] rout,
                                     logic gout, logic dinout, logic ain, logic gin,
                                     logic addsub, logic done, logic busy, logic illegal);
    return {irin, rin, rout, gout, dinout, ain, gin, addsub, done, busy, illegal};
  endfunction

  function automatic logic [24:0] obs();
    return {pif.IRin, pif.Rin, pif.Rout, pif.Gout, pif.DINout, pif.Ain, pif.Gin,
            pif.AddSub, pif.Done, pif.Busy, pif.Illegal};
  endfunction

  task automatic push(string tag, logic rstn, logic run, logic [15:0] din, logic gnz,
                      logic [24:0] v);
    stim_t s;
    exp_t  e;
    s.rstn = rstn; s.run = run; s.din = din; s.gnz = gnz;
    e.tag = tag; e.v = v;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Every-cycle invariants.
  always @(negedge Pclk) begin
    total++;
    if (!$onehot0({pif.Rout, pif.Gout, pif.DINout})) begin
      bad++;
      $display("FAIL busmux_onehot: got Rout=%h Gout=%b DINout=%b want at most one driver",
               pif.Rout, pif.Gout, pif.DINout);
    end
    total++;
    if (!$onehot0(pif.Rin)) begin
      bad++;
      $display("FAIL rin_onehot: got Rin=%h want at most one bit", pif.Rin);
    end
    total++;
    if (pif.Done && done_prev) begin
      bad++;
      $display("FAIL done_twice: got Done=1 in consecutive cycles want single pulse");
    end
    done_prev = pif.Done;
  end

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    push("rst_idle",    1'b0, 1'b0, 16'h0000, 1'b0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("rst_irin",    1'b0, 1'b1, 16'h2000, 1'b0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("rst_release", 1'b1, 1'b0, 16'h0000, 1'b1, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(posedge Pclk); #1;
      Resetn = s.rstn; pif.Run = s.run; pif.DIN = s.din; pif.Gnz = s.gnz;
      @(negedge Pclk);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_mvi_mv();
    stim_t s;
    exp_t  e;
    // mvi R0,#5
    push("mvi_t0",   1, 1, 16'h2000, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("mvi_t1",   1, 0, 16'h0005, 0, mk(0, 8'h01, 8'h00, 0,1,0,0,0,1,1,0));
    push("idle",     1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    // mv R1,R0
    push("mv_t0",    1, 1, 16'h0400, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("mv_t1",    1, 0, 16'h0000, 0, mk(0, 8'h02, 8'h01, 0,0,0,0,0,1,1,0));
    push("idle",     1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(posedge Pclk); #1;
      Resetn = s.rstn; pif.Run = s.run; pif.DIN = s.din; pif.Gnz = s.gnz;
      @(negedge Pclk);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_add();
    stim_t s;
    exp_t  e;
    // add R0,R1
    push("add_t0", 1, 1, 16'h4080, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("add_t1", 1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h01, 0,0,1,0,0,0,1,0));
    push("add_t2", 1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h02, 0,0,0,1,0,0,1,0));
    push("add_t3", 1, 0, 16'h0000, 0, mk(0, 8'h01, 8'h00, 1,0,0,0,0,1,1,0));
    push("idle",   1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    // add R3,R3 (doubling)
    push("dbl_t0", 1, 1, 16'h4D80, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("dbl_t1", 1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h08, 0,0,1,0,0,0,1,0));
    push("dbl_t2", 1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h08, 0,0,0,1,0,0,1,0));
    push("dbl_t3", 1, 0, 16'h0000, 0, mk(0, 8'h08, 8'h00, 1,0,0,0,0,1,1,0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(posedge Pclk); #1;
      Resetn = s.rstn; pif.Run = s.run; pif.DIN = s.din; pif.Gnz = s.gnz;
      @(negedge Pclk);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    // sub R2,R3 with Run held high: no fetch until the cycle after Done.
    push("sub_t0", 1, 1, 16'h6980, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("sub_t1", 1, 1, 16'hE000, 0, mk(0, 8'h00, 8'h04, 0,0,1,0,0,0,1,0));
    push("sub_t2", 1, 1, 16'hE000, 0, mk(0, 8'h00, 8'h08, 0,0,0,1,1,0,1,0));
    push("sub_t3", 1, 1, 16'hE000, 0, mk(0, 8'h04, 8'h00, 1,0,0,0,0,1,1,0));
    // immediate refetch: mv R1,R0
    push("b2b_t0", 1, 1, 16'h0400, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("b2b_t1", 1, 0, 16'h0000, 0, mk(0, 8'h02, 8'h01, 0,0,0,0,0,1,1,0));
    push("idle",   1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(posedge Pclk); #1;
      Resetn = s.rstn; pif.Run = s.run; pif.DIN = s.din; pif.Gnz = s.gnz;
      @(negedge Pclk);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_mvnz_illegal();
    stim_t s;
    exp_t  e;
    // mvnz R4,R5; Gnz is only looked at in T1.
    push("mvnz0_t0", 1, 1, 16'h9280, 1, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("mvnz0_t1", 1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,1,1,0));
    push("mvnz1_t0", 1, 1, 16'h9280, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("mvnz1_t1", 1, 0, 16'h0000, 1, mk(0, 8'h10, 8'h20, 0,0,0,0,0,1,1,0));
    // opcodes 111 and 101
    push("ill7_t0",  1, 1, 16'hE000, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("ill7_t1",  1, 0, 16'h0000, 1, mk(0, 8'h00, 8'h00, 0,0,0,0,0,1,1,1));
    push("ill5_t0",  1, 1, 16'hA000, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("ill5_t1",  1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,1,1,1));
    push("idle",     1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(posedge Pclk); #1;
      Resetn = s.rstn; pif.Run = s.run; pif.DIN = s.din; pif.Gnz = s.gnz;
      @(negedge Pclk);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    exp_t  e;
    push("rmid_t0",  1, 1, 16'h4080, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("rmid_t1",  1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h01, 0,0,1,0,0,0,1,0));
    push("rmid_rst", 0, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("rmid_hld", 0, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("rmid_rel", 1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    // IR was cleared: a fresh mvi must behave normally.
    push("rmid_f0",  1, 1, 16'h2000, 0, mk(1, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    push("rmid_f1",  1, 0, 16'h0007, 0, mk(0, 8'h01, 8'h00, 0,1,0,0,0,1,1,0));
    push("idle",     1, 0, 16'h0000, 0, mk(0, 8'h00, 8'h00, 0,0,0,0,0,0,0,0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(posedge Pclk); #1;
      Resetn = s.rstn; pif.Run = s.run; pif.DIN = s.din; pif.Gnz = s.gnz;
      @(negedge Pclk);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e.v) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", e.tag, obs(), e.v);
      end
    end
  endtask

  initial begin
    Resetn  = 1'b0;
    pif.Run = 1'b0;
    pif.DIN = '0;
    pif.Gnz = 1'b0;
    test_reset();
    test_mvi_mv();
    test_add();
    test_back_to_back();
    test_mvnz_illegal();
    test_reset_mid();
    @(posedge Pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
